// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM states, block geometry and address slicing.
package cache_pkg;

    localparam int ADDR_W            = 16;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Block-aligned part of a byte address (drops the 16-byte block offset).
    function automatic logic [ADDR_W-1:BLOCK_OFFSET_BITS] block_base_of(
        input logic [ADDR_W-1:0] addr
    );
        return addr[ADDR_W-1:BLOCK_OFFSET_BITS];
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag.
module fill_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Refills one 8-word cache block after a miss: eight back-to-back word reads,
// then one data-array write per returned word, with the tag written on the last.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_WIDTH-1:0]    miss_address,
    input  logic                     memory_data_valid,
    output logic                     fsm_busy,
    output logic                     write_data_array,
    output logic                     write_tag_array,
    output logic [WORD_IDX_BITS-1:0] word_num,
    output logic                     mem_req,
    output logic [ADDR_WIDTH-1:0]    memory_address
);

    if (ADDR_WIDTH != ADDR_W || WORDS_PER_BLOCK != cache_pkg::WORDS_PER_BLOCK
        || MEM_LATENCY < 1) begin : g_param_check
        $error("cache_fill_fsm: unsupported parameter set");
    end

    fill_state_t state;
    fill_state_t next_state;

    logic [ADDR_WIDTH-1:BLOCK_OFFSET_BITS] block_base;
    logic [WORD_IDX_BITS:0]                req_cnt;
    logic [WORD_IDX_BITS-1:0]              resp_cnt;
    logic [WORD_IDX_BITS-1:0]              req_idx;
    logic                                  req_done;
    logic                                  resp_last;
    logic                                  start;
    logic                                  req_en;
    logic                                  resp_en;

    fill_counter #(
        .WIDTH    (WORD_IDX_BITS + 1),
        .TERMINAL (WORDS_PER_BLOCK)
    ) u_req_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (req_en),
        .count (req_cnt),
        .done  (req_done)
    );

    fill_counter #(
        .WIDTH    (WORD_IDX_BITS),
        .TERMINAL (WORDS_PER_BLOCK - 1)
    ) u_resp_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (resp_en),
        .count (resp_cnt),
        .done  (resp_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Block base is pure data: only loaded at the start of a fill, never reset.
    always_ff @(posedge clk) begin
        if (start) begin
            block_base <= block_base_of(miss_address);
        end
    end

    // Once all requests are out the counter sits at 8; keep pointing at the last word.
    assign req_idx = req_cnt[WORD_IDX_BITS] ? {WORD_IDX_BITS{1'b1}}
                                            : req_cnt[WORD_IDX_BITS-1:0];

    always_comb begin
        next_state       = state;
        start            = 1'b0;
        req_en           = 1'b0;
        resp_en          = 1'b0;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_num         = '0;

        case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    start      = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                fsm_busy       = 1'b1;
                mem_req        = !req_done;
                req_en         = !req_done;
                memory_address = {block_base, req_idx, 1'b0};
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_num         = resp_cnt;
                    resp_en          = 1'b1;
                    if (resp_last) begin
                        write_tag_array = 1'b1;
                        next_state      = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: in-order memory model with optional bubbles and a
// per-cycle reference model of the refill protocol.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  word_num;
    logic        mem_req;
    logic [15:0] memory_address;

    cache_fill_fsm #(
        .ADDR_WIDTH      (16),
        .WORDS_PER_BLOCK (8),
        .MEM_LATENCY     (LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_num          (word_num),
        .mem_req           (mem_req),
        .memory_address    (memory_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory: ready times of outstanding reads, served in order.
    int q[$];

    // Reference model of the refill in progress.
    bit         active = 1'b0;
    int         start_c = 0;
    logic [11:0] base = '0;
    int         resp = 0;

    bit gap_en = 1'b0;
    bit stray_en = 1'b0;
    bit check_en = 1'b0;

    int          obs_req, obs_wr, obs_tag, obs_busy;
    logic [15:0] obs_last_addr;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_req = 0;
        obs_wr = 0;
        obs_tag = 0;
        obs_busy = 0;
        obs_last_addr = '0;
    endtask

    task automatic step(input logic m, input logic [15:0] a, input logic r);
        logic        v;
        logic        e_busy, e_req, e_wda, e_wta;
        logic [15:0] e_addr;
        logic [2:0]  e_wn;
        int          kk, k;
        @(negedge clk);
        rst = r;
        miss_detected = m;
        miss_address = a;
        v = 1'b0;
        if (q.size() > 0 && q[0] <= cyc && !(gap_en && $urandom_range(0, 2) == 0)) begin
            v = 1'b1;
            void'(q.pop_front());
        end else if (stray_en && !active && $urandom_range(0, 1) == 1) begin
            v = 1'b1;
        end
        memory_data_valid = v;
        #1;
        kk = cyc - start_c;
        k = (kk > 8) ? 8 : kk;
        e_busy = active | m;
        e_req  = active && kk <= 8;
        e_addr = active ? ({base, 4'h0} + 16'(2 * (k - 1))) : 16'h0;
        e_wda  = active & v;
        e_wn   = e_wda ? 3'(resp) : 3'd0;
        e_wta  = e_wda && resp == 7;
        if (check_en) begin
            chk("fsm_busy", 16'(fsm_busy), 16'(e_busy));
            chk("mem_req", 16'(mem_req), 16'(e_req));
            chk("memory_address", memory_address, e_addr);
            chk("write_data_array", 16'(write_data_array), 16'(e_wda));
            chk("word_num", 16'(word_num), 16'(e_wn));
            chk("write_tag_array", 16'(write_tag_array), 16'(e_wta));
        end
        if (mem_req === 1'b1) begin
            q.push_back(cyc + LAT);
            obs_req++;
            obs_last_addr = memory_address;
        end
        if (fsm_busy === 1'b1) obs_busy++;
        if (write_data_array === 1'b1) obs_wr++;
        if (write_tag_array === 1'b1) obs_tag++;
        @(posedge clk);
        if (r) begin
            active = 1'b0;
            q.delete();
        end else if (!active) begin
            if (m) begin
                active = 1'b1;
                start_c = cyc;
                base = a[15:4];
                resp = 0;
            end
        end else if (v) begin
            if (resp == 7) active = 1'b0;
            resp++;
        end
        cyc++;
    endtask

    // Runs until the model sees the fill complete; an exhausted budget is a failure.
    task automatic run_fill(input int budget, input bit noisy);
        int n = 0;
        while (active && n < budget) begin
            if (noisy) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
            else       step(1'b0, 16'($urandom), 1'b0);
            n++;
        end
        chk("fill_completes_in_budget", 16'(active), 16'(0));
    endtask

    initial begin
        logic [15:0] a;
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = '0;
        memory_data_valid = 1'b0;
        clear_obs();

        // Reset: busy follows miss_detected, everything else quiet.
        check_en = 1'b0;
        step(1'b0, 16'h0000, 1'b1);
        check_en = 1'b1;
        step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'h5555, 1'b1);
        step(1'b0, 16'h0000, 1'b0);

        // Single miss at 0x1236 with fixed memory latency.
        clear_obs();
        step(1'b1, 16'h1236, 1'b0);
        repeat (13) step(1'b0, 16'($urandom), 1'b0);
        chk("single_req_count", 16'(obs_req), 16'd8);
        chk("single_last_addr", obs_last_addr, 16'h123E);
        chk("single_write_count", 16'(obs_wr), 16'd8);
        chk("single_tag_count", 16'(obs_tag), 16'd1);
        chk("single_busy_cycles", 16'(obs_busy), 16'd13);

        // Back-to-back: I-miss at 0x0040, D-miss at 0xFFF0 held behind it.
        clear_obs();
        step(1'b1, 16'h0040, 1'b0);
        repeat (12) step(1'b1, 16'hFFF0, 1'b0);
        step(1'b1, 16'hFFF0, 1'b0);
        run_fill(40, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("b2b_req_count", 16'(obs_req), 16'd16);
        chk("b2b_last_addr", obs_last_addr, 16'hFFFE);
        chk("b2b_tag_count", 16'(obs_tag), 16'd2);
        chk("b2b_busy_cycles", 16'(obs_busy), 16'd26);

        // Random blocks, response bubbles, input noise and stray valids in IDLE.
        gap_en = 1'b1;
        stray_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (3) step(1'b0, 16'($urandom), 1'b0);
            clear_obs();
            a = 16'($urandom);
            step(1'b1, a, 1'b0);
            run_fill(80, 1'b1);
            chk("rand_req_count", 16'(obs_req), 16'd8);
            chk("rand_last_addr", obs_last_addr, {a[15:4], 4'hE});
            chk("rand_write_count", 16'(obs_wr), 16'd8);
            chk("rand_tag_count", 16'(obs_tag), 16'd1);
        end
        gap_en = 1'b0;
        stray_en = 1'b0;
        step(1'b0, 16'h0000, 1'b0);

        // Reset mid-fill at cycle 6, new miss at 0x2000 on cycle 9.
        step(1'b1, 16'($urandom), 1'b0);
        repeat (5) step(1'b0, 16'($urandom), 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        clear_obs();
        repeat (2) step(1'b0, 16'h0000, 1'b0);
        chk("post_reset_quiet", 16'(obs_busy + obs_wr + obs_req), 16'd0);
        step(1'b1, 16'h2000, 1'b0);
        run_fill(40, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("rst_refill_req_count", 16'(obs_req), 16'd8);
        chk("rst_refill_last_addr", obs_last_addr, 16'h200E);
        chk("rst_refill_tag_count", 16'(obs_tag), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
